pipe_skid_reg: RTL and testbench

- Parametrised elastic pipeline-stage register for the five-stage core; replaces the fixed-width, always-advancing inter-stage latches.
- Carries a control bundle, an rd tag and a data payload between stages, using a valid/ready handshake with per-stage stall and flush.
- SKID=1 adds a 2-entry skid buffer so ready_o is fully registered; SKID=0 gives a single-entry register with a combinational ready path.
- Bubbles always present all-zero control, so a downstream MemRead/MemWrite/RegWrite never fires on an invalid slot.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_entry_reg.sv | 38 +++
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit positions, default widths
// and the stage payload layout used by the inter-stage registers.
package pipe_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int CTRL_W_DEF = 4;
   localparam int RD_W_DEF   = 5;

   // WB bits in the upper half of the bundle, M bits in the lower half
   localparam int WB_REGWRITE = 3;
   localparam int WB_MEMTOREG = 2;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;

   typedef struct packed {
      logic [CTRL_W_DEF-1:0] ctrl;
      logic [RD_W_DEF-1:0]   rd;
      logic [DATA_W_DEF-1:0] data;
   } stage_payload_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot: valid bit plus ctrl/rd/data payload.
// Clear drops only the valid bit; load captures valid and payload together.
module pipe_entry_reg #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 4,
   parameter int RD_W   = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              ld_i,
   input  logic              valid_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [RD_W-1:0]   rd_d,
   input  logic [DATA_W-1:0] data_d,
   output logic              valid_q,
   output logic [CTRL_W-1:0] ctrl_q,
   output logic [RD_W-1:0]   rd_q,
   output logic [DATA_W-1:0] data_q
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         rd_q    <= '0;
         data_q  <= '0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end else if (ld_i) begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic inter-stage register with valid/ready, stall and flush.
// SKID=1: head + skid slot, ready_o from a flop. SKID=0: one slot, combinational ready.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int RD_W   = RD_W_DEF,
   parameter int SKID   = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [RD_W-1:0]   rd_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [RD_W-1:0]   rd_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        count_o
);

   logic              accept, emit;
   logic              main_v, main_ld, main_vd;
   logic [CTRL_W-1:0] main_ctrl, main_cd;
   logic [RD_W-1:0]   main_rd, main_rdd;
   logic [DATA_W-1:0] main_data, main_dd;

   assign accept = valid_i && ready_o;
   assign emit   = main_v && ready_i;

   pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_i),
      .ld_i    (main_ld),
      .valid_d (main_vd),
      .ctrl_d  (main_cd),
      .rd_d    (main_rdd),
      .data_d  (main_dd),
      .valid_q (main_v),
      .ctrl_q  (main_ctrl),
      .rd_q    (main_rd),
      .data_q  (main_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic              skid_v, skid_ld;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [RD_W-1:0]   skid_rd;
         logic [DATA_W-1:0] skid_data;

         // Skid fills only on a stalled head; it drains into the head on emit,
         // at which point ready_o is low so the load clears it.
         assign skid_ld = (main_v && !emit && accept) || (skid_v && emit);

         pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (flush_i),
            .ld_i    (skid_ld),
            .valid_d (accept),
            .ctrl_d  (ctrl_i),
            .rd_d    (rd_i),
            .data_d  (data_i),
            .valid_q (skid_v),
            .ctrl_q  (skid_ctrl),
            .rd_q    (skid_rd),
            .data_q  (skid_data)
         );

         assign ready_o  = !skid_v;
         assign main_ld  = (!main_v && accept) || emit;
         assign main_vd  = skid_v || accept;
         assign main_cd  = skid_v ? skid_ctrl : ctrl_i;
         assign main_rdd = skid_v ? skid_rd   : rd_i;
         assign main_dd  = skid_v ? skid_data : data_i;
         assign count_o  = {1'b0, main_v} + {1'b0, skid_v};
      end else begin : g_single
         assign ready_o  = !main_v || ready_i;
         assign main_ld  = accept || emit;
         assign main_vd  = accept;
         assign main_cd  = ctrl_i;
         assign main_rdd = rd_i;
         assign main_dd  = data_i;
         assign count_o  = {1'b0, main_v};
      end
   endgenerate

   // Bubbles carry zero control so no memory or writeback strobe leaks out
   assign valid_o = main_v;
   assign ctrl_o  = main_v ? main_ctrl : '0;
   assign rd_o    = main_rd;
   assign data_o  = main_data;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus and compares
// both against queue-based reference models every cycle.
module tb_pipe_skid_reg;

   typedef struct packed {
      logic [3:0]  c;
      logic [4:0]  r;
      logic [63:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, flush, vin, rdy;
   logic [3:0]  cin;
   logic [4:0]  rin;
   logic [63:0] din;

   logic        r1, v1, r0, v0;
   logic [3:0]  c1, c0;
   logic [4:0]  rd1, rd0;
   logic [63:0] d1, d0;
   logic [1:0]  n1, n0;

   int checks = 0;
   int failures = 0;
   ent_t q1[$];
   ent_t q0[$];

   always #5 clk = ~clk;

   pipe_skid_reg #(.SKID(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(r1),
      .ctrl_i(cin), .rd_i(rin), .data_i(din), .valid_o(v1), .ready_i(rdy),
      .ctrl_o(c1), .rd_o(rd1), .data_o(d1), .count_o(n1)
   );

   pipe_skid_reg #(.SKID(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(r0),
      .ctrl_i(cin), .rd_i(rin), .data_i(din), .valid_o(v0), .ready_i(rdy),
      .ctrl_o(c0), .rd_o(rd0), .data_o(d0), .count_o(n0)
   );

   task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model-side readiness: the skid version can take a new entry whenever it
   // holds fewer than two; the single version when empty or draining this cycle.
   function automatic logic mdl_ready(input int cap, input int size, input logic rdy_in);
      if (cap == 2) return size < 2;
      return (size == 0) || rdy_in;
   endfunction

   task automatic check_all();
      ent_t h;
      cmp("s1.valid", {63'd0, v1}, {63'd0, q1.size() > 0});
      cmp("s1.count", {62'd0, n1}, 64'(q1.size()));
      cmp("s1.ready", {63'd0, r1}, {63'd0, mdl_ready(2, q1.size(), rdy)});
      if (q1.size() > 0) begin
         h = q1[0];
         cmp("s1.ctrl", {60'd0, c1}, {60'd0, h.c});
         cmp("s1.rd",   {59'd0, rd1}, {59'd0, h.r});
         cmp("s1.data", d1, h.d);
      end else cmp("s1.ctrl_bubble", {60'd0, c1}, 64'd0);
      cmp("s0.valid", {63'd0, v0}, {63'd0, q0.size() > 0});
      cmp("s0.count", {62'd0, n0}, 64'(q0.size()));
      cmp("s0.ready", {63'd0, r0}, {63'd0, mdl_ready(1, q0.size(), rdy)});
      if (q0.size() > 0) begin
         h = q0[0];
         cmp("s0.ctrl", {60'd0, c0}, {60'd0, h.c});
         cmp("s0.rd",   {59'd0, rd0}, {59'd0, h.r});
         cmp("s0.data", d0, h.d);
      end else cmp("s0.ctrl_bubble", {60'd0, c0}, 64'd0);
   endtask

   task automatic model_edge();
      ent_t e;
      logic in1, out1, in0, out0;
      e = '{c: cin, r: rin, d: din};
      in1  = vin && mdl_ready(2, q1.size(), rdy);
      out1 = (q1.size() > 0) && rdy;
      in0  = vin && mdl_ready(1, q0.size(), rdy);
      out0 = (q0.size() > 0) && rdy;
      if (rst || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (out1) void'(q1.pop_front());
         if (in1)  q1.push_back(e);
         if (out0) void'(q0.pop_front());
         if (in0)  q0.push_back(e);
      end
   endtask

   // One cycle: drive inputs, check outputs (combinational ready sees the new
   // ready_i), then advance the model to match the coming edge.
   task automatic step(input logic v, input logic [3:0] c, input logic [63:0] d,
                       input logic rd_in, input logic fl, input logic rs);
      @(negedge clk);
      vin = v; cin = c; din = d; rin = d[4:0] ^ 5'h15;
      rdy = rd_in; flush = fl; rst = rs;
      #1;
      check_all();
      model_edge();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy = 1'b0;
      cin = '0; rin = '0; din = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      cmp("rst.s1.valid", {63'd0, v1}, 64'd0);
      cmp("rst.s1.ctrl",  {60'd0, c1}, 64'd0);
      cmp("rst.s1.rd",    {59'd0, rd1}, 64'd0);
      cmp("rst.s1.data",  d1, 64'd0);
      cmp("rst.s1.count", {62'd0, n1}, 64'd0);
      cmp("rst.s1.ready", {63'd0, r1}, 64'd1);
      cmp("rst.s0.data",  d0, 64'd0);
      cmp("rst.s0.count", {62'd0, n0}, 64'd0);
      model_edge();

      // Streaming at full rate
      for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 64'(i), 1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Backpressure: A, B, C stalled, then release with C still offered
      step(1'b1, 4'h1, 64'hA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h2, 64'hB, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h4, 64'hC, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h4, 64'hC, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, 4'h4, 64'hC, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Flush while full, with an entry offered in the same cycle
      step(1'b1, 4'h8, 64'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h9, 64'h22, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'hF, 64'h33, 1'b0, 1'b1, 1'b0);
      repeat (2) step(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Single-entry stall and same-cycle replace
      step(1'b1, 4'h5, 64'h55, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h6, 64'h66, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'h6, 64'h66, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      // Bubbles with memory strobes on the control input
      repeat (4) step(1'b0, 4'b0011, 64'hDEAD, 1'b1, 1'b0, 1'b0);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++)
         step(1'($urandom), 4'($urandom), {$urandom, $urandom}, 1'($urandom),
              ($urandom_range(31) == 0), ($urandom_range(63) == 0));
      step(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
